// File: rtl/eth_rx_packer.sv
// ---------------------------------------------------------------------------
// eth_rx_packer
// Ethernet receive front end. Packs the received byte stream into 16-bit
// little-endian words and writes them into the receive buffer. Frame length
// and status are handed to firmware through an arm/done/ack handshake.
// Frames that arrive while the block is not armed are dropped and counted.
//
// Ports
//   eth_clk_i   : Ethernet receive clock (only clock)
//   eth_rstn_i  : asynchronous active-low reset
//   rx_dv_i     : frame envelope, high for the whole frame
//   rx_stb_i    : byte strobe, only meaningful while rx_dv_i=1
//   rx_dat_i    : received byte
//   rx_er_i     : receive error, sampled during the frame
//   arm_i       : pulse, buffer is free for the next frame
//   ack_i       : pulse, firmware has consumed the status
//   eth_adr_o   : buffer word address
//   eth_dat_o   : buffer write data {odd byte, even byte}
//   eth_we_o    : buffer write enable, one pulse per word
//   done_o      : frame complete, held until ack_i
//   len_o       : bytes stored for the last frame
//   ovf_o       : frame exceeded buffer capacity
//   err_o       : rx_er_i was seen during the frame
//   runt_o      : len_o < MINLEN
//   drop_o      : saturating count of dropped frames
// ---------------------------------------------------------------------------
module eth_rx_packer #(
  parameter int AW     = 10,
  parameter int MINLEN = 60
) (
  input  logic          eth_clk_i,
  input  logic          eth_rstn_i,
  input  logic          rx_dv_i,
  input  logic          rx_stb_i,
  input  logic [7:0]    rx_dat_i,
  input  logic          rx_er_i,
  input  logic          arm_i,
  input  logic          ack_i,
  output logic [AW-1:0] eth_adr_o,
  output logic [15:0]   eth_dat_o,
  output logic          eth_we_o,
  output logic          done_o,
  output logic [AW+1:0] len_o,
  output logic          ovf_o,
  output logic          err_o,
  output logic          runt_o,
  output logic [7:0]    drop_o
);

  localparam int            CAP_INT = 2 ** (AW + 1);
  localparam logic [AW+1:0] CAP     = CAP_INT[AW+1:0];
  localparam logic [AW+1:0] MINL    = MINLEN[AW+1:0];

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RECV, S_FLUSH, S_DONE, S_DROP
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_dvPrev;
  logic [AW+1:0] r_cnt;
  logic [AW-1:0] r_adr;
  logic [7:0]    r_latch;
  logic [AW-1:0] r_ethAdr;
  logic [15:0]   r_wdat;
  logic          r_we;
  logic          r_ovf;
  logic          r_err;
  logic          r_runt;
  logic [7:0]    r_drop;
  logic          r_armPend;

  logic          w_dvRise;
  logic          w_accept;
  logic          w_done;
  logic          w_enterWait;
  logic          w_countDrop;

  assign w_dvRise = rx_dv_i & ~r_dvPrev;

  // State register
  always_ff @(posedge eth_clk_i or negedge eth_rstn_i) begin
    if (!eth_rstn_i) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  // Next-state logic. In IDLE arm wins over a coincident frame start: that
  // frame began before WAIT, so it is neither captured nor counted.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (arm_i)         w_next = S_WAIT;
        else if (w_dvRise) w_next = S_DROP;
      end
      S_WAIT:  if (w_dvRise) w_next = S_RECV;
      S_RECV:  if (!rx_dv_i) w_next = r_cnt[0] ? S_FLUSH : S_DONE;
      S_FLUSH: w_next = S_DONE;
      // A frame that started during DONE has already been counted; if it is
      // still running at ack time, sit it out in DROP without recounting.
      S_DONE:  if (ack_i) w_next = rx_dv_i ? S_DROP : S_IDLE;
      S_DROP:  if (!rx_dv_i) w_next = (r_armPend | arm_i) ? S_WAIT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output / qualifier logic
  always_comb begin
    w_done      = (r_state == S_DONE);
    w_accept    = (r_state == S_RECV) & rx_dv_i & rx_stb_i;
    w_enterWait = (w_next == S_WAIT) & (r_state != S_WAIT);
    w_countDrop = ((r_state == S_IDLE) & (w_next == S_DROP)) |
                  ((r_state == S_DONE) & w_dvRise);
  end

  // Datapath: byte packing, buffer write port, status and drop counter.
  // The address saturates at the last word so nothing is written past it.
  always_ff @(posedge eth_clk_i or negedge eth_rstn_i) begin
    if (!eth_rstn_i) begin
      r_dvPrev  <= 1'b0;
      r_cnt     <= '0;
      r_adr     <= '0;
      r_latch   <= '0;
      r_ethAdr  <= '0;
      r_wdat    <= '0;
      r_we      <= 1'b0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
      r_runt    <= 1'b0;
      r_drop    <= '0;
      r_armPend <= 1'b0;
    end else begin
      r_dvPrev <= rx_dv_i;
      r_we     <= 1'b0;

      if (w_enterWait) begin
        r_cnt  <= '0;
        r_adr  <= '0;
        r_ovf  <= 1'b0;
        r_err  <= 1'b0;
        r_runt <= 1'b0;
      end

      if (r_state == S_RECV) begin
        if (rx_dv_i && rx_er_i) r_err <= 1'b1;
        if (w_accept) begin
          if (r_cnt == CAP) begin
            r_ovf <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (!r_cnt[0]) begin
              r_latch <= rx_dat_i;
            end else begin
              r_wdat   <= {rx_dat_i, r_latch};
              r_ethAdr <= r_adr;
              r_we     <= 1'b1;
              if (r_adr != {AW{1'b1}}) r_adr <= r_adr + 1'b1;
            end
          end
        end
      end

      if (r_state == S_FLUSH) begin
        r_wdat   <= {8'h00, r_latch};
        r_ethAdr <= r_adr;
        r_we     <= 1'b1;
      end

      if ((w_next == S_DONE) && (r_state != S_DONE)) r_runt <= (r_cnt < MINL);

      if (w_countDrop && (r_drop != 8'hFF)) r_drop <= r_drop + 1'b1;

      // Remember an arm that arrives while a dropped frame is still running
      if (r_state == S_DROP) begin
        if (w_next != S_DROP) r_armPend <= 1'b0;
        else if (arm_i)       r_armPend <= 1'b1;
      end
    end
  end

  assign eth_adr_o = r_ethAdr;
  assign eth_dat_o = r_wdat;
  assign eth_we_o  = r_we;
  assign done_o    = w_done;
  assign len_o     = r_cnt;
  assign ovf_o     = r_ovf;
  assign err_o     = r_err;
  assign runt_o    = r_runt;
  assign drop_o    = r_drop;

endmodule

// File: tb/tb_eth_rx_packer.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_packer
// Directed bench for eth_rx_packer. Frame stimulus pushes the expected buffer
// writes into a queue; a monitor pops and compares every write the DUT makes.
// Status outputs are compared against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_eth_rx_packer;

  localparam int AW   = 10;
  localparam int CAPB = 2 ** (AW + 1);

  logic          clk = 1'b0;
  logic          rstn;
  logic          rxDv, rxStb, rxEr, arm, ack;
  logic [7:0]    rxDat;
  logic [AW-1:0] ethAdr;
  logic [15:0]   ethDat;
  logic          ethWe, done, ovf, err, runt;
  logic [AW+1:0] len;
  logic [7:0]    drop;

  always #5 clk = ~clk;

  eth_rx_packer #(.AW(AW), .MINLEN(60)) dut (
    .eth_clk_i (clk),
    .eth_rstn_i(rstn),
    .rx_dv_i   (rxDv),
    .rx_stb_i  (rxStb),
    .rx_dat_i  (rxDat),
    .rx_er_i   (rxEr),
    .arm_i     (arm),
    .ack_i     (ack),
    .eth_adr_o (ethAdr),
    .eth_dat_o (ethDat),
    .eth_we_o  (ethWe),
    .done_o    (done),
    .len_o     (len),
    .ovf_o     (ovf),
    .err_o     (err),
    .runt_o    (runt),
    .drop_o    (drop)
  );

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [15:0]   dat;
  } wr_t;

  wr_t           expQ[$];
  int            nChecks = 0;
  int            nFails  = 0;
  int            nWrites = 0;
  int            snap;
  logic [AW-1:0] lastAdr = '0;
  logic [15:0]   lastDat = '0;

  // Monitor: every buffer write must match the head of the expected queue
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (ethWe === 1'b1) begin
        nWrites++;
        lastAdr = ethAdr;
        lastDat = ethDat;
        nChecks++;
        if (expQ.size() == 0) begin
          nFails++;
          $display("[TB] FAIL unexpectedWrite got adr=%0d dat=%h, required no write", ethAdr, ethDat);
        end else begin
          e = expQ.pop_front();
          if (ethAdr !== e.adr || ethDat !== e.dat) begin
            nFails++;
            $display("[TB] FAIL bufWrite got adr=%0d dat=%h, required adr=%0d dat=%h",
                     ethAdr, ethDat, e.adr, e.dat);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s got %0d, required %0d", name, act, exp);
    end
  endtask

  // Expected writes for the first n bytes of an incrementing-byte frame
  task automatic pushExp(input int n, input bit withFlush);
    wr_t w;
    for (int i = 1; i < n && i < CAPB; i += 2) begin
      w.adr = AW'(i / 2);
      w.dat = {8'(i), 8'(i - 1)};
      expQ.push_back(w);
    end
    if (withFlush && (n % 2 == 1) && n < CAPB) begin
      w.adr = AW'(n / 2);
      w.dat = {8'h00, 8'(n - 1)};
      expQ.push_back(w);
    end
  endtask

  task automatic sendBytes(input int first, input int n, input int erAt);
    for (int i = first; i < first + n; i++) begin
      @(posedge clk); #1;
      rxStb = 1'b1;
      rxDat = 8'(i);
      rxEr  = (i == erAt);
    end
    @(posedge clk); #1;
    rxStb = 1'b0;
    rxEr  = 1'b0;
  endtask

  // One complete frame of n incrementing bytes; store=1 when it should land
  task automatic applyStimulus(input int n, input int erAt, input bit store);
    if (store) pushExp(n, 1'b1);
    @(posedge clk); #1;
    rxDv = 1'b1;
    sendBytes(0, n, erAt);
    rxDv = 1'b0;
  endtask

  task automatic pulseArm();
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
  endtask

  task automatic pulseAck();
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checkOutput(name, 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0; rxDv = 1'b0; rxStb = 1'b0; rxEr = 1'b0;
    rxDat = 8'h00; arm = 1'b0; ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetDone", 32'(done), 0);
    checkOutput("resetWe", 32'(ethWe), 0);
    checkOutput("resetDrop", 32'(drop), 0);
    checkOutput("resetLen", 32'(len), 0);
    checkOutput("resetAdr", 32'(ethAdr), 0);
    checkOutput("resetDat", 32'(ethDat), 0);
    rstn = 1'b1;

    // 64-byte frame
    pulseArm();
    snap = nWrites;
    applyStimulus(64, -1, 1'b1);
    waitDone("f64Done");
    checkOutput("f64Writes", 32'(nWrites - snap), 32);
    checkOutput("f64LastAdr", 32'(lastAdr), 31);
    checkOutput("f64LastDat", 32'(lastDat), 32'h3F3E);
    checkOutput("f64Len", 32'(len), 64);
    checkOutput("f64Runt", 32'(runt), 0);
    checkOutput("f64Err", 32'(err), 0);
    checkOutput("f64Ovf", 32'(ovf), 0);
    pulseAck();

    // 61-byte frame: odd length, flush of the pending byte
    pulseArm();
    snap = nWrites;
    applyStimulus(61, -1, 1'b1);
    waitDone("f61Done");
    checkOutput("f61Writes", 32'(nWrites - snap), 31);
    checkOutput("f61LastAdr", 32'(lastAdr), 30);
    checkOutput("f61LastDat", 32'(lastDat), 32'h003C);
    checkOutput("f61Len", 32'(len), 61);
    checkOutput("f61Runt", 32'(runt), 0);
    pulseAck();

    // 2100-byte frame: overflow, no write past the last word
    pulseArm();
    snap = nWrites;
    applyStimulus(2100, -1, 1'b1);
    waitDone("fOvfDone");
    checkOutput("fOvfWrites", 32'(nWrites - snap), 1024);
    checkOutput("fOvfLastAdr", 32'(lastAdr), 1023);
    checkOutput("fOvfLastDat", 32'(lastDat), 32'hFFFE);
    checkOutput("fOvfLen", 32'(len), 2048);
    checkOutput("fOvfFlag", 32'(ovf), 1);
    pulseAck();

    // Frame without arm is dropped; then an armed frame with rx_er_i
    snap = nWrites;
    applyStimulus(30, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("dropWrites", 32'(nWrites - snap), 0);
    checkOutput("dropCount1", 32'(drop), 1);
    checkOutput("dropNoDone", 32'(done), 0);
    pulseArm();
    applyStimulus(64, 10, 1'b1);
    waitDone("fErrDone");
    checkOutput("fErrFlag", 32'(err), 1);
    checkOutput("fErrOvfClr", 32'(ovf), 0);
    checkOutput("fErrLen", 32'(len), 64);
    checkOutput("fErrDrop", 32'(drop), 1);
    pulseAck();

    // Runt frame, then a frame without re-arm after ack
    pulseArm();
    applyStimulus(20, -1, 1'b1);
    waitDone("fRuntDone");
    checkOutput("fRuntFlag", 32'(runt), 1);
    checkOutput("fRuntLen", 32'(len), 20);
    checkOutput("fRuntErrClr", 32'(err), 0);
    pulseAck();
    @(negedge clk);
    checkOutput("ackDropsDone", 32'(done), 0);
    checkOutput("ackHoldsLen", 32'(len), 20);
    applyStimulus(16, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("dropCount2", 32'(drop), 2);
    checkOutput("noReArmDone", 32'(done), 0);

    // Arm coinciding with a frame start: frame neither stored nor counted
    snap = nWrites;
    @(posedge clk); #1;
    arm = 1'b1;
    rxDv = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    sendBytes(0, 8, -1);
    rxDv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("armRaceWrites", 32'(nWrites - snap), 0);
    checkOutput("armRaceDrop", 32'(drop), 2);
    checkOutput("armRaceDone", 32'(done), 0);

    // Zero-byte frame while still armed
    applyStimulus(0, -1, 1'b1);
    waitDone("fZeroDone");
    checkOutput("fZeroLen", 32'(len), 0);
    checkOutput("fZeroRunt", 32'(runt), 1);
    pulseAck();

    // Reset in the middle of a frame, right while a write is presented
    pulseArm();
    pushExp(10, 1'b0);
    @(posedge clk); #1;
    rxDv = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      rxStb = 1'b1;
      rxDat = 8'(i);
      @(posedge clk); #1;
    end
    rxStb = 1'b0;
    @(negedge clk); #1;
    rstn = 1'b0;
    #1;
    checkOutput("rstWeLow", 32'(ethWe), 0);
    checkOutput("rstDoneLow", 32'(done), 0);
    checkOutput("rstDropClr", 32'(drop), 0);
    checkOutput("rstLenClr", 32'(len), 0);
    snap = nWrites;
    @(posedge clk); #1;
    rstn = 1'b1;
    sendBytes(10, 10, -1);
    rxDv = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rstNoWrites", 32'(nWrites - snap), 0);
    checkOutput("rstNoDone", 32'(done), 0);
    checkOutput("queueDrained", 32'(expQ.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/eth_rx_packer.md
Name: eth_rx_packer

Overview:
- Ethernet receive front end that sits directly upstream of the receive buffer's Ethernet port.
- Packs the received byte stream into 16-bit little-endian words and drives buffer address, data and write-enable in the Ethernet clock domain.
- Reports frame length and status to firmware through an arm/done/ack handshake.
- Frames arriving while the block is not armed are dropped and counted.

Parameters:
- AW, 10, buffer word-address width; buffer capacity is 2^AW words = 2^(AW+1) bytes.
- MINLEN, 60, minimum legal frame length in bytes; shorter frames set the runt flag.

Ports:
- eth_clk_i  in  1  Ethernet receive clock; the only clock.
- eth_rstn_i  in  1  asynchronous active-low reset.
- rx_dv_i  in  1  frame envelope; high for the whole frame.
- rx_stb_i  in  1  byte strobe, meaningful only while rx_dv_i=1.
- rx_dat_i  in  8  received byte, sampled when rx_stb_i=1.
- rx_er_i  in  1  receive error, sampled while rx_dv_i=1.
- arm_i  in  1  single-cycle pulse: buffer is free, accept the next frame.
- ack_i  in  1  single-cycle pulse: firmware has consumed the status.
- eth_adr_o  out  AW  buffer word address.
- eth_dat_o  out  16  buffer write data.
- eth_we_o  out  1  buffer write-enable, one-cycle pulse per word.
- done_o  out  1  frame complete; held until ack_i.
- len_o  out  AW+2  bytes stored for the last frame.
- ovf_o  out  1  frame exceeded buffer capacity.
- err_o  out  1  rx_er_i was seen during the frame.
- runt_o  out  1  len_o < MINLEN.
- drop_o  out  8  count of dropped frames, saturating at 255.

Behaviour:
- Reset (asynchronous, eth_rstn_i=0): state IDLE; all outputs 0; byte counter, address, byte latch and drop counter cleared. Reset mid-frame abandons the frame with no further writes.
- States: IDLE, WAIT, RECV, FLUSH, DONE, DROP.
- IDLE:
  - arm_i -> WAIT.
  - Rising edge of rx_dv_i (registered previous value 0, current 1) -> DROP.
- WAIT: clears byte counter, address, ovf, err and runt on entry. Rising edge of rx_dv_i -> RECV. If rx_dv_i is already high when WAIT is entered, the block ignores it and waits for the next rising edge.
- RECV, byte handling:
  - Each rx_stb_i byte goes to the even slot when byte-count bit 0 = 0, and is latched.
  - On an odd slot, the next cycle presents eth_dat_o={odd byte, even byte}, eth_adr_o=current address, and eth_we_o=1 (registered, 1-cycle latency); the address then increments.
  - rx_er_i=1 in any cycle sets err.
- RECV, overflow: once the byte count reaches 2^(AW+1), further bytes are discarded and ovf is set. The address never wraps; there is no write beyond the last word.
- RECV, frame end: rx_dv_i falling edge -> FLUSH if an even byte is pending, else -> DONE.
  - A strobe coinciding with the falling edge is not accepted; rx_stb_i is ignored when rx_dv_i=0.
- FLUSH: one cycle; writes {8'h00, pending byte} at the current address; -> DONE.
- DONE:
  - done_o=1; len_o equals the stored byte count; runt = (len_o < MINLEN); status outputs are stable.
  - ack_i -> IDLE, done_o drops the next cycle; status outputs hold their values until the next WAIT entry.
  - A frame arriving in DONE is dropped: -> DROP path deferred, and drop_o increments on its rising edge.
  - arm_i in DONE is ignored.
- DROP: drop_o increments (saturating) on entry; waits for rx_dv_i=0 -> IDLE. A pending arm_i during DROP is remembered, so the exit goes -> WAIT instead of IDLE.
- eth_we_o is never high in IDLE, WAIT, DONE or DROP.
- Simultaneous arm_i and rx_dv_i rising edge in IDLE: arm wins; the frame is not captured (it started before WAIT) and is not counted as dropped.
- Zero-byte frame (rx_dv_i pulse with no strobes) -> DONE with len_o=0 and runt_o=1.

Test Plan:
- Arm, 64-byte frame with bytes 0x00..0x3F -> 32 writes; word 0 = 16'h0100 at address 0, word 31 = 16'h3F3E at address 31; done_o=1, len_o=64, runt_o=0, err_o=0.
- Arm, 61-byte frame -> 31 writes; last write at address 30 with data {8'h00, byte60}; len_o=61.
- Arm, 2100-byte frame with AW=10 -> exactly 1024 writes; no write after address 1023; len_o=2048, ovf_o=1.
- Frame sent without arm, then arm and frame with rx_er_i pulsed mid-frame -> drop_o=1; second frame stored with err_o=1.
- Arm, 20-byte frame -> runt_o=1, len_o=20; ack_i then a frame without re-arm -> done_o=0, drop_o increments.
- Assert eth_rstn_i=0 mid-frame after 10 bytes -> eth_we_o=0 immediately, state IDLE; after release, remaining bytes produce no writes and no done_o.
